// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX serializer among N requesters
// Ports: clk_3125/rst (async, active-high) clock and reset; en gates new grants;
// req/req_data per-requester level request and byte; gnt one-hot grant pulse;
// tx_start/tx_data launch strobe and byte; tx_done end-of-frame pulse from serializer;
// busy not idle; err_timeout watchdog pulse; frame_cnt completed-frame counter.
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int GAP_CLKS     = 27,
    parameter int TIMEOUT_CLKS = 320
) (
    input  logic           clk_3125,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   gnt,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic           tx_done,
    output logic           busy,
    output logic           err_timeout,
    output logic [15:0]    frame_cnt
);
    localparam int LW = $clog2(N);
    localparam int MX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
    localparam int CW = $clog2(MX) + 1;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] GAP       = 2'd2;
    // With no gap the frame end returns straight to IDLE.
    localparam logic [1:0] POST      = (GAP_CLKS == 0) ? IDLE : GAP;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] last, win;
    logic [LW:0]   idx;

    assign busy = state != IDLE;

    // Scan offsets from far to near so the nearest set request after last wins.
    always_comb begin
        win = last;
        idx = '0;
        for (int i = N; i > 0; i--) begin
            idx = (LW + 1)'(last) + (LW + 1)'(i);
            idx = (idx >= (LW + 1)'(N)) ? idx - (LW + 1)'(N) : idx;
            if (req[idx]) win = idx[LW-1:0];
        end
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= LW'(N - 1);
            gnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            err_timeout <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            gnt         <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && |req) begin
                        gnt      <= N'(1) << win;
                        tx_start <= 1'b1;
                        tx_data  <= req_data[{win, 3'b000} +: 8];
                        last     <= win;
                        cnt      <= '0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        cnt       <= '0;
                        state     <= POST;
                    end else if (cnt == CW'(TIMEOUT_CLKS - 1)) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= POST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CW'(GAP_CLKS - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a time-based reference model of the arbiter
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int GAP = 27;
    localparam int TO  = 320;

    logic          clk_3125 = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0] req_data = {8'h4D, 8'hA5, 8'h3C, 8'h81};
    logic [N-1:0]  gnt;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done = 1'b0;
    logic          busy;
    logic          err_timeout;
    logic [15:0]   frame_cnt;

    uart_tx_arbiter #(.N(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) dut (
        .clk_3125(clk_3125), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    always #160 clk_3125 = ~clk_3125;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int preload_evt = 0;
    int gq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a frame occupies the transmitter from its start edge until
    // done or the watchdog; the next grant may not come before done edge + GAP + 1.
    initial begin : model
        int t_free, t_start, m_last, seen, w;
        bit in_flight, found;
        logic [15:0] m_frames;
        logic [N-1:0] e_gnt, s_req;
        logic [7:0] e_data;
        logic e_start, e_err, e_busy, s_en, s_done, s_rst;
        logic [8*N-1:0] s_data;
        t_free = 0; t_start = 0; m_last = N - 1; seen = 0; in_flight = 0;
        m_frames = 0; e_gnt = 0; e_data = 0; e_start = 0; e_err = 0; e_busy = 0;
        forever begin
            @(posedge clk_3125);
            s_en = en; s_req = req; s_data = req_data; s_done = tx_done; s_rst = rst;
            cyc++;
            e_gnt = 0; e_start = 0; e_err = 0;
            if (preload_evt != seen) begin
                seen = preload_evt;
                m_frames = 16'hFFFF;
            end
            if (s_rst) begin
                t_free = 0; in_flight = 0; m_last = N - 1; m_frames = 0; e_data = 0;
            end else if (in_flight) begin
                if (s_done) begin
                    m_frames = m_frames + 16'd1;
                    in_flight = 0;
                    t_free = cyc + GAP + 1;
                end else if (cyc - t_start == TO) begin
                    e_err = 1;
                    in_flight = 0;
                    t_free = cyc + GAP + 1;
                end
            end else if (cyc >= t_free && s_en && |s_req) begin
                found = 0; w = 0;
                for (int o = 1; o <= N; o++)
                    if (!found && s_req[(m_last + o) % N]) begin
                        found = 1;
                        w = (m_last + o) % N;
                    end
                in_flight = 1;
                t_start = cyc;
                m_last = w;
                e_data = s_data[8*w +: 8];
                e_gnt = N'(1) << w;
                e_start = 1;
            end
            e_busy = !s_rst && (in_flight || cyc < t_free - 1);
            #1;
            chk("gnt", gnt, e_gnt);
            chk("tx_start", tx_start, e_start);
            chk("tx_data", tx_data, e_data);
            chk("busy", busy, e_busy);
            chk("err_timeout", err_timeout, e_err);
            chk("frame_cnt", frame_cnt, m_frames);
            chk("gnt_onehot", $onehot0(gnt), 1);
            for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
        end
    end

    task automatic nt(input int n);
        repeat (n) @(negedge clk_3125);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        nt(1);
        tx_done = 1'b0;
    endtask

    task automatic wait_start(output int w);
        bit found;
        found = 0;
        w = -1;
        for (int k = 0; k < 1000 && !found; k++) begin
            nt(1);
            if (tx_start) begin
                found = 1;
                for (int i = 0; i < N; i++) if (gnt[i]) w = i;
            end
        end
        chk("grant_seen", found, 1);
    endtask

    initial begin : stim
        int w;
        int order[5];
        int qs;
        nt(3);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        en = 1'b1;
        nt(2);

        // single requester, done 297 clocks after start
        req = 4'b0100;
        wait_start(w);
        chk("single_gnt", gnt, 4'b0100);
        chk("single_data", tx_data, 8'hA5);
        req = '0;
        nt(296);
        pulse_done();
        chk("single_frames", frame_cnt, 1);
        nt(26);
        chk("single_busy_gap", busy, 1);
        nt(1);
        chk("single_busy_idle", busy, 0);

        // reset in the middle of a frame
        req = 4'b0010;
        wait_start(w);
        chk("pre_rst_winner", w, 1);
        req = '0;
        nt(50);
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_start", tx_start, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_timeout, 0);
        chk("arst_frames", frame_cnt, 0);
        nt(1);
        rst = 1'b0;

        // round robin with all requesting
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(w);
            order[i] = w;
            if (i == 4) req = 4'b0010;
            nt(10);
            pulse_done();
        end
        for (int i = 0; i < 5; i++) chk("rr_order", order[i], i % 4);
        wait_start(w);
        chk("rr_to_1", w, 1);
        req = 4'b1010;
        nt(10);
        pulse_done();
        wait_start(w);
        chk("rr_skip_to_3", w, 3);
        req = '0;
        nt(10);
        pulse_done();
        nt(30);
        chk("rr_frames", frame_cnt, 7);

        // watchdog
        req = 4'b0001;
        wait_start(w);
        chk("to_winner", w, 0);
        req = '0;
        nt(319);
        chk("to_early", err_timeout, 0);
        nt(1);
        chk("to_pulse", err_timeout, 1);
        chk("to_frames", frame_cnt, 7);
        nt(26);
        chk("to_busy_gap", busy, 1);
        nt(1);
        chk("to_busy_idle", busy, 0);

        // done on the timeout cycle, then a spurious done in IDLE
        req = 4'b0001;
        wait_start(w);
        req = '0;
        nt(319);
        pulse_done();
        chk("sim_err", err_timeout, 0);
        chk("sim_frames", frame_cnt, 8);
        nt(40);
        pulse_done();
        chk("spurious_frames", frame_cnt, 8);
        chk("spurious_busy", busy, 0);

        // enable gating and counter wrap
        en = 1'b0;
        req = 4'b0001;
        qs = gq.size();
        nt(100);
        chk("en_no_grant", gq.size(), qs);
        chk("en_idle", busy, 0);
        en = 1'b1;
        nt(1);
        chk("en_gnt", gnt, 4'b0001);
        chk("en_start", tx_start, 1);
        req = '0;
        nt(1);
        chk("en_gnt_one_cycle", gnt, 0);
        force dut.frame_cnt = 16'hFFFF;
        preload_evt++;
        #1;
        release dut.frame_cnt;
        nt(5);
        pulse_done();
        chk("wrap_frames", frame_cnt, 16'h0000);
        nt(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
